banzai_axil_arbiter: RTL and testbench
======================================

Name: banzai_axil_arbiter

Overview:
- Parametrised N-to-1 AXI-Lite interconnect for the banzAI control path.
- Generalises the fixed two-slave-port accelerator front end to NumSlaves ports.
- Independent round-robin arbitration on the write and read paths onto one downstream AXI-Lite master.
- Address-window decode: requests outside the window get a local DECERR and are never forwarded.

Parameters:
- NumSlaves, 2, number of upstream AXI-Lite slave ports (>=1).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; strobe width is DataWidth/8.
- BaseAddr, 32'h0000_0000, lowest address forwarded downstream.
- WindowSize, 32'h0001_0000, window size in bytes. Forwarded iff BaseAddr <= addr < BaseAddr+WindowSize, compared in AddrWidth+1 bits so the sum cannot wrap.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- s_awaddr_i  in  NumSlaves*AddrWidth  per-port AW address; port k occupies slice [k*AddrWidth +: AddrWidth] (same slicing on all s_ buses).
- s_awprot_i  in  NumSlaves*3  AW prot.
- s_awvalid_i / s_awready_o  in/out  NumSlaves  AW handshake.
- s_wdata_i  in  NumSlaves*DataWidth  W data.
- s_wstrb_i  in  NumSlaves*DataWidth/8  W strobe.
- s_wvalid_i / s_wready_o  in/out  NumSlaves  W handshake.
- s_bresp_o  out  NumSlaves*2  B response.
- s_bvalid_o / s_bready_i  out/in  NumSlaves  B handshake.
- s_araddr_i  in  NumSlaves*AddrWidth  AR address.
- s_arprot_i  in  NumSlaves*3  AR prot.
- s_arvalid_i / s_arready_o  in/out  NumSlaves  AR handshake.
- s_rdata_o  out  NumSlaves*DataWidth  R data.
- s_rresp_o  out  NumSlaves*2  R response.
- s_rvalid_o / s_rready_i  out/in  NumSlaves  R handshake.
- m_aw*/m_w*/m_b*/m_ar*/m_r*  mirror  scalar widths  downstream AXI-Lite master (awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp[1:0], bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp[1:0], rvalid, rready).

Behaviour:
- Single clock clk_i; rst_i is asynchronous, active-high.
- Reset values:
  - Both FSMs IDLE; both RR pointers 0; grant registers 0.
  - All s_*ready_o, s_*valid_o and m_*valid_o are 0; m_bready_o and m_rready_o are 0.
  - Data and response outputs are 0.
- Write FSM states: W_IDLE, W_FWD, W_RESP, W_ERR.
  - W_IDLE: if any s_awvalid, pick the first requester at or after the RR pointer. Register the grant g and the AW address decode hit. Set pointer to g+1 mod NumSlaves. Go to W_FWD on hit, W_ERR on miss. Arbitration costs one cycle; no ready is asserted in W_IDLE.
  - W_FWD:
    - AW path: m_aw* = port g, until the AW handshake.
    - W path: m_w* = port g, until the W handshake.
    - Each side is tracked by its own done flag; AW and W may complete in either order or in the same cycle.
    - s_awready[g] = m_awready while AW is not done; s_wready[g] likewise for W. Go to W_RESP when both are done.
  - W_RESP: s_bvalid[g] = m_bvalid, s_bresp[g] = m_bresp, m_bready = s_bready[g]. Go to W_IDLE on the B handshake.
  - W_ERR:
    - Accept AW and W locally by pulsing s_awready[g] and s_wready[g] (independently, each once).
    - Then hold s_bvalid[g]=1 with bresp=2'b11 until s_bready[g].
    - Go to W_IDLE; nothing is driven downstream.
- Read FSM states: R_IDLE, R_FWD, R_RESP, R_ERR.
  - Same structure as the write FSM, with its own pointer.
  - R_ERR returns rdata=0, rresp=2'b11.
  - R_FWD goes to R_RESP on the AR handshake; R_RESP goes to R_IDLE on the R handshake.
- Read and write paths are fully independent: the same or different ports may be granted concurrently.
- Exactly one outstanding transaction per direction.
- Non-granted ports see ready=0 and valid=0 on their response channels.
- Valid stability: m_*valid is never deasserted before its handshake (a pure mux of a stable AXI source under a locked grant).
- Reset mid-transaction drops everything; no response is owed after reset.

Decomposition:
- Package banzai_axil_pkg:
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Enums wr_state_e and rd_state_e.
  - Function in_window(addr).
- Sub-module banzai_rr_arbiter (params NumReq):
  - Inputs: req vector, advance strobe.
  - Outputs: grant index plus any.
  - Holds the RR pointer; instantiated once for the write path and once for the read path.

Test Plan:
- Single write: port 0 writes 0x10 with data 0xDEADBEEF, downstream bvalid returns after 3 cycles with OKAY → m_awaddr=0x10, m_wdata=0xDEADBEEF, s_bresp[0]=00, s_bvalid[0] for one handshake.
- Contention, NumSlaves=4: ports 1, 2, 3 assert awvalid simultaneously with the pointer at 2 → service order 2, 3, 1; pointer ends at 2.
- Decode miss: port 1 reads 0x0002_0000 with the default window → m_arvalid never rises; s_rresp[1]=11, s_rdata=0.
- Concurrency: port 0 write and port 1 read issued in the same cycle → both forwarded in parallel and both complete without mutual stall.
- Ordering: W arrives 4 cycles before AW, downstream holds bvalid under bready=0 for 5 cycles → no duplicate handshakes and bresp stable while stalled.
- Async reset asserted mid-W_FWD → all valids and readys 0 immediately; after release a new write completes normally.

Source files
------------

// File: rtl/banzai_axil_pkg.sv
// banzAI AXI-Lite interconnect shared types.
// Response codes, FSM states and window decode.
package banzai_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE, W_FWD, W_RESP, W_ERR
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE, R_FWD, R_RESP, R_ERR
  } rd_state_e;

  // One extra bit keeps base+size from wrapping.
  function automatic logic in_window(
    input logic [63:0] addr,
    input logic [63:0] base,
    input logic [63:0] size
  );
    logic [64:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/banzai_rr_arbiter.sv
// Round-robin requester pick with a registered pointer.
// Pointer moves to grant+1 on each advance strobe.
module banzai_rr_arbiter #(
  parameter int NumReq = 2,
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              adv_i,
  output logic [IdxW-1:0]   gnt_o,
  output logic              any_o
);

  logic [IdxW-1:0] ptr;
  int j;

  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    j = 0;
    for (int i = 0; i < NumReq; i++) begin
      j = (int'(ptr) + i) % NumReq;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        gnt_o = IdxW'(j);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (adv_i) begin
      if (int'(gnt_o) == NumReq - 1) ptr <= '0;
      else ptr <= gnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/banzai_axil_arbiter.sv
// N-to-1 AXI-Lite interconnect with independent
// round-robin write/read paths and window decode.
module banzai_axil_arbiter
  import banzai_axil_pkg::*;
#(
  parameter int NumSlaves = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr = '0,
  parameter logic [AddrWidth-1:0] WindowSize =
    AddrWidth'(32'h0001_0000)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [NumSlaves*AddrWidth-1:0] s_awaddr_i,
  input  logic [NumSlaves*3-1:0] s_awprot_i,
  input  logic [NumSlaves-1:0] s_awvalid_i,
  output logic [NumSlaves-1:0] s_awready_o,
  input  logic [NumSlaves*DataWidth-1:0] s_wdata_i,
  input  logic [NumSlaves*DataWidth/8-1:0] s_wstrb_i,
  input  logic [NumSlaves-1:0] s_wvalid_i,
  output logic [NumSlaves-1:0] s_wready_o,
  output logic [NumSlaves*2-1:0] s_bresp_o,
  output logic [NumSlaves-1:0] s_bvalid_o,
  input  logic [NumSlaves-1:0] s_bready_i,
  input  logic [NumSlaves*AddrWidth-1:0] s_araddr_i,
  input  logic [NumSlaves*3-1:0] s_arprot_i,
  input  logic [NumSlaves-1:0] s_arvalid_i,
  output logic [NumSlaves-1:0] s_arready_o,
  output logic [NumSlaves*DataWidth-1:0] s_rdata_o,
  output logic [NumSlaves*2-1:0] s_rresp_o,
  output logic [NumSlaves-1:0] s_rvalid_o,
  input  logic [NumSlaves-1:0] s_rready_i,
  output logic [AddrWidth-1:0] m_awaddr_o,
  output logic [2:0] m_awprot_o,
  output logic m_awvalid_o,
  input  logic m_awready_i,
  output logic [DataWidth-1:0] m_wdata_o,
  output logic [DataWidth/8-1:0] m_wstrb_o,
  output logic m_wvalid_o,
  input  logic m_wready_i,
  input  logic [1:0] m_bresp_i,
  input  logic m_bvalid_i,
  output logic m_bready_o,
  output logic [AddrWidth-1:0] m_araddr_o,
  output logic [2:0] m_arprot_o,
  output logic m_arvalid_o,
  input  logic m_arready_i,
  input  logic [DataWidth-1:0] m_rdata_i,
  input  logic [1:0] m_rresp_i,
  input  logic m_rvalid_i,
  output logic m_rready_o
);

  localparam int IdxW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
  localparam int SW = DataWidth / 8;

  wr_state_e wr_st;
  rd_state_e rd_st;
  logic [IdxW-1:0] wr_g, wr_arb_g, rd_g, rd_arb_g;
  logic wr_any, wr_adv, wr_hit, aw_done, w_done;
  logic aw_rdy, w_rdy, aw_hs, w_hs, b_vld, b_hs;
  logic rd_any, rd_adv, rd_hit, ar_done;
  logic ar_rdy, ar_hs, r_vld, r_hs;

  banzai_rr_arbiter #(.NumReq(NumSlaves)) u_wr_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (s_awvalid_i),
    .adv_i (wr_adv),
    .gnt_o (wr_arb_g),
    .any_o (wr_any)
  );

  banzai_rr_arbiter #(.NumReq(NumSlaves)) u_rd_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (s_arvalid_i),
    .adv_i (rd_adv),
    .gnt_o (rd_arb_g),
    .any_o (rd_any)
  );

  assign wr_adv = (wr_st == W_IDLE) && wr_any;
  assign rd_adv = (rd_st == R_IDLE) && rd_any;
  assign wr_hit = in_window(
    64'(s_awaddr_i[wr_arb_g*AddrWidth +: AddrWidth]),
    64'(BaseAddr), 64'(WindowSize));
  assign rd_hit = in_window(
    64'(s_araddr_i[rd_arb_g*AddrWidth +: AddrWidth]),
    64'(BaseAddr), 64'(WindowSize));

  // W_ERR accepts locally; W_FWD passes downstream ready.
  assign aw_rdy = !aw_done &&
    ((wr_st == W_FWD && m_awready_i) || wr_st == W_ERR);
  assign w_rdy = !w_done &&
    ((wr_st == W_FWD && m_wready_i) || wr_st == W_ERR);
  assign aw_hs = aw_rdy && s_awvalid_i[wr_g];
  assign w_hs = w_rdy && s_wvalid_i[wr_g];
  assign b_vld = (wr_st == W_RESP && m_bvalid_i) ||
    (wr_st == W_ERR && aw_done && w_done);
  assign b_hs = b_vld && s_bready_i[wr_g];

  assign ar_rdy = (rd_st == R_FWD && m_arready_i) ||
    (rd_st == R_ERR && !ar_done);
  assign ar_hs = ar_rdy && s_arvalid_i[rd_g];
  assign r_vld = (rd_st == R_RESP && m_rvalid_i) ||
    (rd_st == R_ERR && ar_done);
  assign r_hs = r_vld && s_rready_i[rd_g];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_st <= W_IDLE;
      wr_g <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      unique case (wr_st)
        W_IDLE: if (wr_any) begin
          wr_g <= wr_arb_g;
          aw_done <= 1'b0;
          w_done <= 1'b0;
          wr_st <= wr_hit ? W_FWD : W_ERR;
        end
        W_FWD: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs) w_done <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs))
            wr_st <= W_RESP;
        end
        W_RESP: if (b_hs) wr_st <= W_IDLE;
        W_ERR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs) w_done <= 1'b1;
          if (b_hs) wr_st <= W_IDLE;
        end
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_st <= R_IDLE;
      rd_g <= '0;
      ar_done <= 1'b0;
    end else begin
      unique case (rd_st)
        R_IDLE: if (rd_any) begin
          rd_g <= rd_arb_g;
          ar_done <= 1'b0;
          rd_st <= rd_hit ? R_FWD : R_ERR;
        end
        R_FWD: if (ar_hs) rd_st <= R_RESP;
        R_RESP: if (r_hs) rd_st <= R_IDLE;
        R_ERR: begin
          if (ar_hs) ar_done <= 1'b1;
          if (r_hs) rd_st <= R_IDLE;
        end
        default: rd_st <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    m_awvalid_o = 1'b0;
    m_awaddr_o = '0;
    m_awprot_o = '0;
    m_wvalid_o = 1'b0;
    m_wdata_o = '0;
    m_wstrb_o = '0;
    s_awready_o = '0;
    s_wready_o = '0;
    s_bvalid_o = '0;
    s_bresp_o = '0;
    if (wr_st == W_FWD) begin
      m_awvalid_o = !aw_done && s_awvalid_i[wr_g];
      m_awaddr_o = s_awaddr_i[wr_g*AddrWidth +: AddrWidth];
      m_awprot_o = s_awprot_i[wr_g*3 +: 3];
      m_wvalid_o = !w_done && s_wvalid_i[wr_g];
      m_wdata_o = s_wdata_i[wr_g*DataWidth +: DataWidth];
      m_wstrb_o = s_wstrb_i[wr_g*SW +: SW];
    end
    m_bready_o = (wr_st == W_RESP) && s_bready_i[wr_g];
    s_awready_o[wr_g] = aw_rdy;
    s_wready_o[wr_g] = w_rdy;
    s_bvalid_o[wr_g] = b_vld;
    if (wr_st == W_RESP)
      s_bresp_o[wr_g*2 +: 2] = m_bresp_i;
    else if (wr_st == W_ERR)
      s_bresp_o[wr_g*2 +: 2] = RESP_DECERR;
  end

  always_comb begin
    m_arvalid_o = 1'b0;
    m_araddr_o = '0;
    m_arprot_o = '0;
    s_arready_o = '0;
    s_rvalid_o = '0;
    s_rdata_o = '0;
    s_rresp_o = '0;
    if (rd_st == R_FWD) begin
      m_arvalid_o = s_arvalid_i[rd_g];
      m_araddr_o = s_araddr_i[rd_g*AddrWidth +: AddrWidth];
      m_arprot_o = s_arprot_i[rd_g*3 +: 3];
    end
    m_rready_o = (rd_st == R_RESP) && s_rready_i[rd_g];
    s_arready_o[rd_g] = ar_rdy;
    s_rvalid_o[rd_g] = r_vld;
    if (rd_st == R_RESP) begin
      s_rdata_o[rd_g*DataWidth +: DataWidth] = m_rdata_i;
      s_rresp_o[rd_g*2 +: 2] = m_rresp_i;
    end else if (rd_st == R_ERR) begin
      s_rresp_o[rd_g*2 +: 2] = RESP_DECERR;
    end
  end

endmodule

// File: tb/tb_banzai_axil_arbiter.sv
// Directed bench for banzai_axil_arbiter, four ports,
// with a transaction-level downstream model and scoreboard.
module tb_banzai_axil_arbiter;
  import banzai_axil_pkg::*;

  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] awaddr[N];
  logic [2:0] awprot[N];
  logic awv[N];
  logic [DW-1:0] wdata[N];
  logic [SW-1:0] wstrb[N];
  logic wv[N];
  logic brdy[N];
  logic [AW-1:0] araddr[N];
  logic [2:0] arprot[N];
  logic arv[N];
  logic rrdy[N];

  logic [N*AW-1:0] s_awaddr_i, s_araddr_i;
  logic [N*3-1:0] s_awprot_i, s_arprot_i;
  logic [N-1:0] s_awvalid_i, s_wvalid_i, s_bready_i;
  logic [N-1:0] s_arvalid_i, s_rready_i;
  logic [N*DW-1:0] s_wdata_i, s_rdata_o;
  logic [N*SW-1:0] s_wstrb_i;
  logic [N-1:0] s_awready_o, s_wready_o, s_bvalid_o;
  logic [N-1:0] s_arready_o, s_rvalid_o;
  logic [N*2-1:0] s_bresp_o, s_rresp_o;

  logic [AW-1:0] m_awaddr_o, m_araddr_o;
  logic [2:0] m_awprot_o, m_arprot_o;
  logic m_awvalid_o, m_wvalid_o, m_bready_o;
  logic m_arvalid_o, m_rready_o;
  logic [DW-1:0] m_wdata_o;
  logic [SW-1:0] m_wstrb_o;
  logic m_awready, m_wready, m_arready;
  logic m_bvalid, m_rvalid;
  logic [1:0] m_bresp, m_rresp;
  logic [DW-1:0] m_rdata;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign s_awaddr_i[k*AW +: AW] = awaddr[k];
    assign s_awprot_i[k*3 +: 3] = awprot[k];
    assign s_awvalid_i[k] = awv[k];
    assign s_wdata_i[k*DW +: DW] = wdata[k];
    assign s_wstrb_i[k*SW +: SW] = wstrb[k];
    assign s_wvalid_i[k] = wv[k];
    assign s_bready_i[k] = brdy[k];
    assign s_araddr_i[k*AW +: AW] = araddr[k];
    assign s_arprot_i[k*3 +: 3] = arprot[k];
    assign s_arvalid_i[k] = arv[k];
    assign s_rready_i[k] = rrdy[k];
  end

  banzai_axil_arbiter #(.NumSlaves(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_awaddr_i(s_awaddr_i), .s_awprot_i(s_awprot_i),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
    .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o),
    .s_bready_i(s_bready_i),
    .s_araddr_i(s_araddr_i), .s_arprot_i(s_arprot_i),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .m_awaddr_o(m_awaddr_o), .m_awprot_o(m_awprot_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready),
    .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid),
    .m_bready_o(m_bready_o),
    .m_araddr_o(m_araddr_o), .m_arprot_o(m_arprot_o),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: expected downstream traffic in service order.
  logic [34:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [34:0] exp_ar[$];
  int wp = 0;
  logic [1:0] sl_bresp = RESP_OKAY;
  int b_lat = 3;
  int r_lat = 2;

  function automatic int rr_pick(input int ptr,
                                 input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (ptr + i) % N;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rd_model(
    input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (m_awvalid_o) begin
        if (exp_aw.size() == 0)
          chk("aw_unexpected", 1, 0);
        else begin
          chk("aw_beat", {m_awprot_o, m_awaddr_o}, exp_aw[0]);
          if (m_awready) void'(exp_aw.pop_front());
        end
      end
      if (m_wvalid_o) begin
        if (exp_w.size() == 0)
          chk("w_unexpected", 1, 0);
        else begin
          chk("w_beat", {m_wstrb_o, m_wdata_o}, exp_w[0]);
          if (m_wready) void'(exp_w.pop_front());
        end
      end
      if (m_arvalid_o) begin
        if (exp_ar.size() == 0)
          chk("ar_unexpected", 1, 0);
        else begin
          chk("ar_beat", {m_arprot_o, m_araddr_o}, exp_ar[0]);
          if (m_arready) void'(exp_ar.pop_front());
        end
      end
      chk("one_bvalid", $countones(s_bvalid_o) <= 1, 1);
      chk("one_rvalid", $countones(s_rvalid_o) <= 1, 1);
      chk("one_awready", $countones(s_awready_o) <= 1, 1);
    end
  end

  // Downstream write slave: B after b_lat cycles.
  initial begin
    int awc, wc, lat;
    logic hs_aw, hs_w, hs_b, busy;
    m_bvalid = 1'b0;
    m_bresp = RESP_OKAY;
    awc = 0; wc = 0; lat = 0; busy = 1'b0;
    forever begin
      @(negedge clk);
      hs_aw = m_awvalid_o && m_awready;
      hs_w = m_wvalid_o && m_wready;
      hs_b = m_bvalid && m_bready_o;
      @(posedge clk); #1;
      if (rst) begin
        awc = 0; wc = 0; busy = 1'b0;
        m_bvalid = 1'b0;
        m_bresp = RESP_OKAY;
      end else begin
        if (hs_aw) awc++;
        if (hs_w) wc++;
        if (hs_b) begin
          m_bvalid = 1'b0;
          m_bresp = RESP_OKAY;
          busy = 1'b0;
        end
        if (busy && !m_bvalid) begin
          lat--;
          if (lat <= 0) begin
            m_bvalid = 1'b1;
            m_bresp = sl_bresp;
          end
        end
        if (!busy && awc > 0 && wc > 0) begin
          awc--; wc--;
          busy = 1'b1;
          lat = b_lat;
        end
      end
    end
  end

  // Downstream read slave: R after r_lat cycles.
  initial begin
    int lat;
    logic hs_ar, hs_r, busy;
    logic [AW-1:0] a, a_s;
    m_rvalid = 1'b0;
    m_rdata = '0;
    m_rresp = RESP_OKAY;
    lat = 0; busy = 1'b0; a = '0; a_s = '0;
    forever begin
      @(negedge clk);
      hs_ar = m_arvalid_o && m_arready;
      hs_r = m_rvalid && m_rready_o;
      a_s = m_araddr_o;
      @(posedge clk); #1;
      if (rst) begin
        busy = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = '0;
      end else begin
        if (hs_r) begin
          m_rvalid = 1'b0;
          m_rdata = '0;
          busy = 1'b0;
        end
        if (busy && !m_rvalid) begin
          lat--;
          if (lat <= 0) begin
            m_rvalid = 1'b1;
            m_rdata = rd_model(a);
            m_rresp = RESP_OKAY;
          end
        end
        if (hs_ar) begin
          a = a_s;
          busy = 1'b1;
          lat = r_lat;
        end
      end
    end
  end

  task automatic do_write(input int p,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d,
                          input int w_lead,
                          input int b_hold,
                          input logic [1:0] er,
                          output int dc);
    int budget, stall;
    logic hs_aw, hs_w, hs_b;
    logic [1:0] r0;
    dc = -1; budget = 0; stall = 0; r0 = '0;
    awaddr[p] = a;
    awprot[p] = 3'(p);
    wdata[p] = d;
    wstrb[p] = 4'hF;
    wv[p] = 1'b1;
    if (w_lead > 0) begin
      repeat (w_lead) @(posedge clk);
      #1;
    end
    awv[p] = 1'b1;
    brdy[p] = (b_hold == 0);
    while (1) begin
      @(negedge clk);
      hs_aw = awv[p] && s_awready_o[p];
      hs_w = wv[p] && s_wready_o[p];
      hs_b = s_bvalid_o[p] && brdy[p];
      if (s_bvalid_o[p] && !brdy[p]) begin
        if (stall == 0) r0 = s_bresp_o[p*2 +: 2];
        else chk("bresp_stable", s_bresp_o[p*2 +: 2], r0);
        stall++;
      end
      if (hs_b) begin
        chk($sformatf("bresp_p%0d", p), s_bresp_o[p*2 +: 2], er);
        chk("b_stall_len", stall, b_hold);
      end
      @(posedge clk); #1;
      if (hs_aw) awv[p] = 1'b0;
      if (hs_w) wv[p] = 1'b0;
      if (hs_b) begin
        brdy[p] = 1'b0;
        dc = cyc;
        break;
      end
      if (stall >= b_hold) brdy[p] = 1'b1;
      budget++;
      if (budget > 300) begin
        chk($sformatf("wr_timeout_p%0d", p), 1, 0);
        awv[p] = 1'b0; wv[p] = 1'b0; brdy[p] = 1'b0;
        break;
      end
    end
    @(negedge clk);
    chk("bvalid_drop", s_bvalid_o[p], 0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int p,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] ed,
                         input logic [1:0] er,
                         output int dc);
    int budget;
    logic hs_ar, hs_r;
    dc = -1; budget = 0;
    araddr[p] = a;
    arprot[p] = 3'(p + 1);
    arv[p] = 1'b1;
    rrdy[p] = 1'b1;
    while (1) begin
      @(negedge clk);
      hs_ar = arv[p] && s_arready_o[p];
      hs_r = s_rvalid_o[p] && rrdy[p];
      if (hs_r) begin
        chk($sformatf("rdata_p%0d", p),
            s_rdata_o[p*DW +: DW], ed);
        chk($sformatf("rresp_p%0d", p),
            s_rresp_o[p*2 +: 2], er);
      end
      @(posedge clk); #1;
      if (hs_ar) arv[p] = 1'b0;
      if (hs_r) begin
        rrdy[p] = 1'b0;
        dc = cyc;
        break;
      end
      budget++;
      if (budget > 300) begin
        chk($sformatf("rd_timeout_p%0d", p), 1, 0);
        arv[p] = 1'b0; rrdy[p] = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, c3, t0, cw, cr, g;
    int ord[$];
    logic [N-1:0] mask;
    for (int k = 0; k < N; k++) begin
      awaddr[k] = '0; awprot[k] = '0; awv[k] = 1'b0;
      wdata[k] = '0; wstrb[k] = '0; wv[k] = 1'b0;
      brdy[k] = 1'b0; araddr[k] = '0; arprot[k] = '0;
      arv[k] = 1'b0; rrdy[k] = 1'b0;
    end
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    awv[0] = 1'b1; wv[0] = 1'b1; arv[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_awvalid", m_awvalid_o, 0);
    chk("rst_m_wvalid", m_wvalid_o, 0);
    chk("rst_m_arvalid", m_arvalid_o, 0);
    chk("rst_m_bready", m_bready_o, 0);
    chk("rst_m_rready", m_rready_o, 0);
    chk("rst_s_awready", s_awready_o, 0);
    chk("rst_s_arready", s_arready_o, 0);
    chk("rst_s_bvalid", s_bvalid_o, 0);
    chk("rst_s_rvalid", s_rvalid_o, 0);
    chk("rst_m_awaddr", m_awaddr_o, 0);
    chk("rst_s_rdata", s_rdata_o, 0);
    awv[0] = 1'b0; wv[0] = 1'b0; arv[1] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write, OKAY after 3 cycles.
    exp_aw.push_back({3'd0, 32'h10});
    exp_w.push_back({4'hF, 32'hDEAD_BEEF});
    sl_bresp = RESP_OKAY;
    do_write(0, 32'h10, 32'hDEAD_BEEF, 0, 0, RESP_OKAY, c0);
    wp = (rr_pick(wp, 4'b0001) + 1) % N;

    // W leads AW by 4 cycles; B stalled 5 cycles.
    exp_aw.push_back({3'd1, 32'h20});
    exp_w.push_back({4'hF, 32'h1234_5678});
    sl_bresp = RESP_SLVERR;
    do_write(1, 32'h20, 32'h1234_5678, 4, 5, RESP_SLVERR, c1);
    wp = (rr_pick(wp, 4'b0010) + 1) % N;
    sl_bresp = RESP_OKAY;

    // Contention of ports 1,2,3 with pointer at 2.
    chk("model_ptr_before", wp, 2);
    mask = 4'b1110;
    ord.delete();
    while (mask != 0) begin
      g = rr_pick(wp, mask);
      ord.push_back(g);
      mask[g] = 1'b0;
      wp = (g + 1) % N;
    end
    chk("model_ord0", ord[0], 2);
    chk("model_ord1", ord[1], 3);
    chk("model_ord2", ord[2], 1);
    chk("model_ptr_after", wp, 2);
    foreach (ord[i]) begin
      exp_aw.push_back({3'(ord[i]), 32'(ord[i] * 256)});
      exp_w.push_back({4'hF, 32'hA000_0000 + 32'(ord[i])});
    end
    fork
      do_write(1, 32'h100, 32'hA000_0001, 0, 0, RESP_OKAY, c1);
      do_write(2, 32'h200, 32'hA000_0002, 0, 0, RESP_OKAY, c2);
      do_write(3, 32'h300, 32'hA000_0003, 0, 0, RESP_OKAY, c3);
    join
    chk("order_2_before_3", c2 < c3, 1);
    chk("order_3_before_1", c3 < c1, 1);

    // Pointer left at 2: ports 1 and 2 serve 2 first.
    g = rr_pick(wp, 4'b0110);
    exp_aw.push_back({3'(g), 32'h400 + 32'(g)});
    exp_w.push_back({4'hF, 32'hB000_0000 + 32'(g)});
    wp = (g + 1) % N;
    g = rr_pick(wp, 4'b0010);
    exp_aw.push_back({3'(g), 32'h400 + 32'(g)});
    exp_w.push_back({4'hF, 32'hB000_0000 + 32'(g)});
    wp = (g + 1) % N;
    fork
      do_write(1, 32'h401, 32'hB000_0001, 0, 0, RESP_OKAY, c1);
      do_write(2, 32'h402, 32'hB000_0002, 0, 0, RESP_OKAY, c2);
    join
    chk("ptr_check_2_first", c2 < c1, 1);

    // Decode misses and window boundary.
    do_read(1, 32'h0002_0000, 32'h0, RESP_DECERR, cr);
    do_write(2, 32'h0001_0000, 32'h5555_5555, 0, 0,
             RESP_DECERR, cw);
    exp_ar.push_back({3'd1, 32'h0000_FFFC});
    do_read(0, 32'h0000_FFFC, rd_model(32'h0000_FFFC),
            RESP_OKAY, cr);

    // Concurrent write on port 0 and read on port 1.
    exp_aw.push_back({3'd0, 32'h40});
    exp_w.push_back({4'hF, 32'hCAFE_F00D});
    exp_ar.push_back({3'd2, 32'h44});
    t0 = cyc;
    fork
      do_write(0, 32'h40, 32'hCAFE_F00D, 0, 0, RESP_OKAY, cw);
      do_read(1, 32'h44, rd_model(32'h44), RESP_OKAY, cr);
    join
    chk("conc_wr_bound", (cw > 0) && (cw - t0 <= 12), 1);
    chk("conc_rd_bound", (cr > 0) && (cr - t0 <= 8), 1);
    chk("conc_rd_not_after_wr", cr <= cw, 1);

    // Asynchronous reset while AW is held downstream.
    m_awready = 1'b0;
    exp_aw.push_back({3'd0, 32'h80});
    exp_w.push_back({4'hF, 32'h8888_8888});
    awaddr[0] = 32'h80; awprot[0] = 3'd0;
    wdata[0] = 32'h8888_8888; wstrb[0] = 4'hF;
    awv[0] = 1'b1; wv[0] = 1'b1; brdy[0] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("fwd_m_awvalid", m_awvalid_o, 1);
    chk("fwd_w_once", s_wready_o[0], 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_awvalid", m_awvalid_o, 0);
    chk("arst_m_wvalid", m_wvalid_o, 0);
    chk("arst_s_awready", s_awready_o, 0);
    chk("arst_s_wready", s_wready_o, 0);
    chk("arst_s_bvalid", s_bvalid_o, 0);
    chk("arst_m_bready", m_bready_o, 0);
    awv[0] = 1'b0; wv[0] = 1'b0; brdy[0] = 1'b0;
    exp_aw.delete();
    exp_w.delete();
    m_awready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_aw.push_back({3'd0, 32'h84});
    exp_w.push_back({4'hF, 32'h0BAD_CAFE});
    do_write(0, 32'h84, 32'h0BAD_CAFE, 0, 0, RESP_OKAY, c0);

    repeat (3) @(posedge clk);
    chk("exp_aw_drained", exp_aw.size(), 0);
    chk("exp_w_drained", exp_w.size(), 0);
    chk("exp_ar_drained", exp_ar.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
